// File: rtl/eth_mode_pkg.sv
// Mode codes shared by the Ethernet mode controller and the bus-mux select decode.
package eth_mode_pkg;

  typedef enum logic [2:0] {
    MODE_INIT    = 3'b000,
    MODE_TX_INIT = 3'b001,
    MODE_TX      = 3'b010,
    MODE_RX_INIT = 3'b011,
    MODE_RX      = 3'b100,
    MODE_IDLE    = 3'b111
  } eth_mode_e;

  localparam int unsigned TIMER_W = 16;

  function automatic logic mode_is_active(input logic [2:0] mode);
    return mode != MODE_IDLE;
  endfunction

endpackage

// File: rtl/eth_mode_ctrl_if.sv
// Request, completion and status signals of the Ethernet mode controller.
interface eth_mode_ctrl_if;

  logic        init_done;
  logic        tx_req;
  logic        rx_irq;
  logic        txi_done;
  logic        tx_done;
  logic        rxi_done;
  logic        rx_done;
  logic        err_clr;
  logic [2:0]  ctl;
  logic        phase_start;
  logic        busy;
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  logic        timeout_err;

  modport master (
    output init_done, tx_req, rx_irq, txi_done, tx_done, rxi_done, rx_done, err_clr,
    input  ctl, phase_start, busy, tx_count, rx_count, timeout_err
  );

  modport slave (
    input  init_done, tx_req, rx_irq, txi_done, tx_done, rxi_done, rx_done, err_clr,
    output ctl, phase_start, busy, tx_count, rx_count, timeout_err
  );

endinterface

// File: rtl/eth_phase_timer.sv
// Per-phase watchdog counter: cleared on state entry, expires at TIMEOUT_CYCLES-1.
module eth_phase_timer
  import eth_mode_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/eth_mode_ctrl.sv
// Ethernet bus mode controller: Init/Tx/Rx phase sequencing with round-robin arbitration.
// Optional per-phase watchdog enabled by defining ETH_MODE_WATCHDOG_EN.
module eth_mode_ctrl
  import eth_mode_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic            sysclk,
  input logic            reset,
  eth_mode_ctrl_if.slave bus
);

  eth_mode_e   state_q, state_d;
  logic        run_q;
  logic        phase_start_q, phase_start_d;
  logic        last_tx_q, last_tx_d;
  logic [15:0] tx_count_q, tx_count_d;
  logic [15:0] rx_count_q, rx_count_d;
  logic        enter;
  logic        timeout;
  logic        expired;
  logic        err_q, err_d;

`ifdef ETH_MODE_WATCHDOG_EN
  eth_phase_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .sysclk (sysclk),
    .reset  (reset),
    .clear  (enter),
    .enable (run_q && mode_is_active(state_q)),
    .expired(expired)
  );
`else
  localparam logic [15:0] TIMEOUT_CFG = 16'(TIMEOUT_CYCLES);
  logic unused_cfg;
  assign unused_cfg = ^{bus.err_clr, TIMEOUT_CFG};
  assign expired    = 1'b0;
`endif

  // The first edge after reset release only starts the machine, so Init gets its own
  // phase_start cycle; a timeout always re-enters Init, even from Init itself.
  always_comb begin
    state_d    = state_q;
    last_tx_d  = last_tx_q;
    tx_count_d = tx_count_q;
    rx_count_d = rx_count_q;
    timeout    = 1'b0;
    if (!run_q) begin
      state_d = MODE_INIT;
    end else begin
      case (state_q)
        MODE_INIT:    if (bus.init_done) state_d = MODE_IDLE;    else timeout = expired;
        MODE_TX_INIT: if (bus.txi_done)  state_d = MODE_TX;      else timeout = expired;
        MODE_RX_INIT: if (bus.rxi_done)  state_d = MODE_RX;      else timeout = expired;
        MODE_TX: begin
          if (bus.tx_done) begin
            state_d    = MODE_IDLE;
            tx_count_d = tx_count_q + 16'd1;
          end else begin
            timeout = expired;
          end
        end
        MODE_RX: begin
          if (bus.rx_done) begin
            state_d    = MODE_IDLE;
            rx_count_d = rx_count_q + 16'd1;
          end else begin
            timeout = expired;
          end
        end
        MODE_IDLE: begin
          if (bus.rx_irq && (!bus.tx_req || last_tx_q)) begin
            state_d   = MODE_RX_INIT;
            last_tx_d = 1'b0;
          end else if (bus.tx_req) begin
            state_d   = MODE_TX_INIT;
            last_tx_d = 1'b1;
          end
        end
        default: state_d = MODE_INIT;
      endcase
      if (timeout) state_d = MODE_INIT;
    end
    enter         = !run_q || timeout || (state_d != state_q);
    phase_start_d = enter && mode_is_active(state_d);
  end

`ifdef ETH_MODE_WATCHDOG_EN
  always_comb begin
    err_d = err_q;
    if (timeout)          err_d = 1'b1;
    else if (bus.err_clr) err_d = 1'b0;
  end
`else
  assign err_d = 1'b0;
`endif

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q       <= MODE_INIT;
      run_q         <= 1'b0;
      phase_start_q <= 1'b0;
      last_tx_q     <= 1'b1;
      tx_count_q    <= '0;
      rx_count_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= 1'b1;
      phase_start_q <= phase_start_d;
      last_tx_q     <= last_tx_d;
      tx_count_q    <= tx_count_d;
      rx_count_q    <= rx_count_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    bus.ctl         = state_q;
    bus.busy        = mode_is_active(state_q);
    bus.phase_start = phase_start_q;
    bus.tx_count    = tx_count_q;
    bus.rx_count    = rx_count_q;
    bus.timeout_err = err_q;
  end

endmodule

// File: doc/eth_mode_ctrl.md
ETH_MODE_CTRL -- requirements
Module: eth_mode_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, cycles allowed per non-Idle phase before watchdog fires (range 2..65535).
REQ-002 Port sysclk  in  1  single system clock; all state changes on rising edge.
REQ-003 Port reset  in  1  asynchronous, active-low reset.
REQ-004 Port init_done  in  1  init engine finished chip setup.
REQ-005 Port tx_req  in  1  level, frame pending for transmit.
REQ-006 Port rx_irq  in  1  level, controller reports received frame (already synchronous to sysclk).
REQ-007 Port txi_done, tx_done, rxi_done, rx_done  in  1 each  one-cycle completion pulses from the four phase engines.
REQ-008 Port err_clr  in  1  clears timeout_err.
REQ-009 Port ctl  out  3  current mode code, drives the bus-mux select.
REQ-010 Port phase_start  out  1  one-cycle pulse on first cycle of each non-Idle mode.
REQ-011 Port busy  out  1  high whenever ctl != Idle.
REQ-012 Port tx_count, rx_count  out  16 each  completed-frame counters.
REQ-013 Port timeout_err  out  1  sticky watchdog flag.

Function
REQ-014 ctl SHALL be registered and equal the state code: Init 000, Transmit_Init 001, Transmit 010, Receive_Init 011, Receive 100, Idle 111.
REQ-015 Init -> Idle on init_done; Transmit_Init -> Transmit on txi_done; Transmit -> Idle on tx_done; Receive_Init -> Receive on rxi_done; Receive -> Idle on rx_done.
REQ-016 Done pulses not matching the current state SHALL be ignored.
REQ-017 Idle with only rx_irq -> Receive_Init; only tx_req -> Transmit_Init; neither -> stay Idle.
REQ-018 Idle with both rx_irq and tx_req -> serve the type not served last (round-robin); after reset last-served = tx, so rx wins first.
REQ-019 Every state SHALL last at least one cycle; a done pulse in the entry cycle is accepted (transition next edge).
REQ-020 phase_start SHALL assert in exactly the first cycle ctl shows a new non-Idle code, including Init after reset release and after watchdog.
REQ-021 tx_count increments on tx_done accepted in Transmit; rx_count on rx_done accepted in Receive; both wrap 0xFFFF -> 0x0000.
REQ-022 Unused codes 101/110 SHALL transition to Init next cycle.

Reset
REQ-023 On reset low: ctl = Init, phase_start = 0, busy = 1, tx_count = 0, rx_count = 0, timeout_err = 0, last-served = tx, timer = 0.
REQ-024 Reset asserted mid-phase SHALL abort immediately; counts of the aborted frame are not incremented.
REQ-025 First cycle after reset release SHALL pulse phase_start with ctl = Init.

Configuration
REQ-026 With ETH_MODE_WATCHDOG_EN defined: timer clears on every state entry, counts each cycle in non-Idle states; at TIMEOUT_CYCLES-1 without the expected done, next state = Init and timeout_err sets.
REQ-027 Done pulse and timeout in the same cycle: done wins, no error.
REQ-028 err_clr clears timeout_err; simultaneous set and clear: set wins.
REQ-029 Without ETH_MODE_WATCHDOG_EN: no timer logic, timeout_err tied 0, err_clr ignored, states wait indefinitely.

Structure
REQ-030 Mode codes SHALL live in shared package eth_mode_pkg, also used by the bus mux select decode.
REQ-031 Watchdog counter SHALL be sub-module eth_phase_timer (clear, enable, expired), instantiated only under ETH_MODE_WATCHDOG_EN.

Verification
REQ-032 Reset release, init_done pulse at cycle 5 -> ctl 000 with phase_start cycle 1, ctl 111 at cycle 6, busy 0.
REQ-033 Idle, tx_req=1, txi_done after 3 cycles, tx_done after 10 -> ctl 001,010,111; tx_count 0->1; two phase_start pulses.
REQ-034 Idle, tx_req=rx_irq=1 held over three transactions -> order Receive, Transmit, Receive.
REQ-035 tx_count preset via 65535 transactions, one more tx_done -> tx_count 0x0000.
REQ-036 Watchdog on, TIMEOUT_CYCLES=16, enter Receive_Init, no rxi_done -> ctl 000 at cycle 16, timeout_err 1; err_clr pulse -> 0.
REQ-037 rx_done pulsed while ctl=001 -> ignored, ctl stays 001, rx_count unchanged.
